// File: rtl/unidade_exibe_sequencia.sv
// -----------------------------------------------------------------------------
// unidade_exibe_sequencia
//
// Plays back the stored sequence of plays for one round. On iniciar it walks
// memory addresses 0..rodada in order. Each play is lit on the LEDs for T_ON
// clocks and is followed by a dark gap of T_OFF clocks. When the last address
// has been shown it pulses fim for one clock.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous reset, active low
//   iniciar    in   start request, only honoured while idle
//   abortar    in   synchronous abort back to idle (no fim pulse)
//   rodada     in   last address to show (inclusive), latched on start
//   dado_mem   in   memory read data, valid one clock after endereco changes
//   endereco   out  memory read address
//   leds       out  LED drive (one-hot play code)
//   ocupado    out  high whenever the block is not idle
//   fim        out  one-clock pulse when playback completes
//   db_estado  out  debug state code (7 = illegal encoding)
// -----------------------------------------------------------------------------
module unidade_exibe_sequencia #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int T_ON   = 500,
    parameter int T_OFF  = 250
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              abortar,
    input  logic [ADDR_W-1:0] rodada,
    input  logic [DATA_W-1:0] dado_mem,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] leds,
    output logic              ocupado,
    output logic              fim,
    output logic [2:0]        db_estado
);

    // The timer only ever counts up to T-1 inside a phase, so it needs just
    // enough bits for max(T_ON,T_OFF)-1.
    localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(T_ON - 1);
    localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(T_OFF - 1);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        ACENDE  = 3'd2,
        APAGA   = 3'd3,
        PROXIMO = 3'd4,
        FIM     = 3'd5
    } estado_t;

    estado_t           estado_q,   estado_d;
    logic [TMR_W-1:0]  timer_q,    timer_d;
    logic [ADDR_W-1:0] endereco_q, endereco_d;
    logic [ADDR_W-1:0] rodada_q,   rodada_d;
    logic [DATA_W-1:0] leds_q,     leds_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            timer_q    <= '0;
            endereco_q <= '0;
            rodada_q   <= '0;
            leds_q     <= '0;
        end else begin
            estado_q   <= estado_d;
            timer_q    <= timer_d;
            endereco_q <= endereco_d;
            rodada_q   <= rodada_d;
            leds_q     <= leds_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        timer_d    = timer_q;
        endereco_d = endereco_q;
        rodada_d   = rodada_q;
        leds_d     = leds_q;

        if (abortar) begin
            estado_d   = OCIOSO;
            timer_d    = '0;
            endereco_d = '0;
            leds_d     = '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    leds_d = '0;
                    if (iniciar) begin
                        rodada_d   = rodada;
                        endereco_d = '0;
                        estado_d   = CARREGA;
                    end
                end
                // Address has been stable for one clock here, so the memory
                // output now belongs to it.
                CARREGA: begin
                    leds_d   = dado_mem;
                    timer_d  = '0;
                    estado_d = ACENDE;
                end
                ACENDE: begin
                    if (timer_q == ON_LAST) begin
                        timer_d  = '0;
                        leds_d   = '0;
                        estado_d = APAGA;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                APAGA: begin
                    if (timer_q == OFF_LAST) begin
                        timer_d  = '0;
                        estado_d = PROXIMO;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                // Compare before incrementing so the top address never wraps.
                PROXIMO: begin
                    if (endereco_q == rodada_q) begin
                        estado_d = FIM;
                    end else begin
                        endereco_d = endereco_q + ADDR_W'(1);
                        estado_d   = CARREGA;
                    end
                end
                FIM: begin
                    estado_d = OCIOSO;
                end
                default: begin
                    estado_d = OCIOSO;
                    timer_d  = '0;
                    leds_d   = '0;
                end
            endcase
        end
    end

    // Moore outputs: decoded from registered state only.
    assign endereco = endereco_q;
    assign leds     = leds_q;
    assign ocupado  = (estado_q != OCIOSO);
    assign fim      = (estado_q == FIM);

    always_comb begin
        case (estado_q)
            OCIOSO, CARREGA, ACENDE, APAGA, PROXIMO, FIM: db_estado = estado_q;
            default:                                      db_estado = 3'd7;
        endcase
    end

endmodule

// File: tb/tb_unidade_exibe_sequencia.sv
// -----------------------------------------------------------------------------
// tb_unidade_exibe_sequencia
//
// Directed bench with T_ON=3, T_OFF=2 (7 clocks per play). The stimulus side
// pushes the expected observable events into a queue before each run; a
// monitor watching the outputs on the falling edge builds events (finished
// LED flash, fim pulse, return to idle) and pops/compares them.
// -----------------------------------------------------------------------------
module tb_unidade_exibe_sequencia;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int T_ON   = 3;
    localparam int T_OFF  = 2;
    localparam int PLAY   = T_ON + T_OFF + 2;

    logic              clock    = 1'b0;
    logic              reset    = 1'b0;
    logic              iniciar  = 1'b0;
    logic              abortar  = 1'b0;
    logic [ADDR_W-1:0] rodada   = '0;
    logic [DATA_W-1:0] dado_mem = '0;
    logic [ADDR_W-1:0] endereco;
    logic [DATA_W-1:0] leds;
    logic              ocupado;
    logic              fim;
    logic [2:0]        db_estado;

    logic [DATA_W-1:0] mem [0:15];

    unidade_exibe_sequencia #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .T_ON  (T_ON),
        .T_OFF (T_OFF)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .iniciar  (iniciar),
        .abortar  (abortar),
        .rodada   (rodada),
        .dado_mem (dado_mem),
        .endereco (endereco),
        .leds     (leds),
        .ocupado  (ocupado),
        .fim      (fim),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Memory model: data for the current address is valid by the rising edge
    // one clock after the address changed.
    always @(negedge clock) dado_mem <= mem[endereco];

    typedef enum int {K_FLASH, K_FIM, K_IDLE} kind_t;
    typedef struct {
        kind_t kind;
        int    a;
        int    b;
        int    c;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic push(input kind_t k, input int a, input int b, input int c);
        ev_t e;
        e.kind = k; e.a = a; e.b = b; e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic observe(input kind_t k, input int a, input int b, input int c);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got a=%0d b=%0d c=%0d expected no event", k.name(), a, b, c);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a != a || e.b != b || e.c != c) begin
                errors++;
                $display("FAIL event: got %s a=%0d b=%0d c=%0d expected %s a=%0d b=%0d c=%0d",
                         k.name(), a, b, c, e.kind.name(), e.a, e.b, e.c);
            end else begin
                $display("ok   %s a=%0d b=%0d c=%0d", k.name(), a, b, c);
            end
        end
    endtask

    // FLASH: a=value, b=address, c=lit clocks
    // FIM:   a={ocupado,fim}, b=address, c=clocks from CARREGA entry
    // IDLE:  a={fim,ocupado,leds}, b=address, c=clocks from CARREGA entry
    initial begin : monitor
        logic [DATA_W-1:0] prev_leds;
        logic [2:0]        prev_db;
        int flen, fval, faddr, cnt;
        prev_leds = '0; prev_db = '0; flen = 0; fval = 0; faddr = 0; cnt = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev_leds = '0; prev_db = '0; flen = 0; cnt = 0;
            end else begin
                cnt++;
                if (db_estado == 3'd1 && prev_db == 3'd0) cnt = 0;
                if (leds != prev_leds && prev_leds != '0)
                    observe(K_FLASH, fval, faddr, flen);
                if (leds != '0) begin
                    if (leds != prev_leds) begin
                        fval = int'(leds); faddr = int'(endereco); flen = 1;
                    end else begin
                        flen++;
                    end
                end
                if (db_estado == 3'd5)
                    observe(K_FIM, int'({ocupado, fim}), int'(endereco), cnt);
                if (db_estado == 3'd0 && prev_db != 3'd0)
                    observe(K_IDLE, int'({fim, ocupado, leds}), int'(endereco), cnt);
                prev_leds = leds;
                prev_db   = db_estado;
            end
        end
    end

    task automatic start_run(input int r);
        @(negedge clock);
        rodada  = ADDR_W'(r);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending events expected 0 after %0d cycles", exp_q.size(), budget);
            exp_q.delete();
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic push_normal(input int r);
        for (int i = 0; i <= r; i++) push(K_FLASH, int'(mem[i]), i, T_ON);
        push(K_FIM, 3, r, (r + 1) * PLAY);
        push(K_IDLE, 0, r, (r + 1) * PLAY + 1);
    endtask

    initial begin : stimulus
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4;
        mem[3] = 4'd8; mem[4] = 4'd1; mem[5] = 4'd2;

        // Reset state
        #12;
        check_eq("rst_endereco", 32'(endereco), 0);
        check_eq("rst_leds", 32'(leds), 0);
        check_eq("rst_ocupado", 32'(ocupado), 0);
        check_eq("rst_fim", 32'(fim), 0);
        check_eq("rst_db_estado", 32'(db_estado), 0);
        @(negedge clock); #2 reset = 1'b1;

        // Asynchronous reset in the middle of ACENDE
        start_run(1);
        @(negedge clock);
        check_eq("pre_rst_leds", 32'(leds), 1);
        #2 reset = 1'b0;
        #1;
        check_eq("async_rst_leds", 32'(leds), 0);
        check_eq("async_rst_ocupado", 32'(ocupado), 0);
        check_eq("async_rst_db_estado", 32'(db_estado), 0);
        @(negedge clock); #2 reset = 1'b1;
        repeat (5) @(negedge clock);
        check_eq("post_rst_db_estado", 32'(db_estado), 0);
        check_eq("post_rst_ocupado", 32'(ocupado), 0);

        // abortar beats iniciar while idle
        @(negedge clock);
        rodada = 4'd2; iniciar = 1'b1; abortar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0; abortar = 1'b0;
        check_eq("abort_vs_start_db_estado", 32'(db_estado), 0);
        check_eq("abort_vs_start_ocupado", 32'(ocupado), 0);

        // Three plays: 1,2,4
        push_normal(2);
        start_run(2);
        drain(200);

        // Same round, with iniciar re-pulsed in APAGA and rodada changed to 5
        push_normal(2);
        start_run(2);
        repeat (4) @(negedge clock);
        iniciar = 1'b1; rodada = 4'd5;
        @(negedge clock);
        iniciar = 1'b0;
        drain(200);

        // Single play of 8
        mem[0] = 4'd8;
        push_normal(0);
        start_run(0);
        drain(100);

        // Abort during the second ACENDE (2 of its 3 clocks shown)
        mem[0] = 4'd1;
        push(K_FLASH, 1, 0, T_ON);
        push(K_FLASH, 2, 1, 2);
        push(K_IDLE, 0, 0, PLAY + 3);
        start_run(2);
        repeat (9) @(negedge clock);
        abortar = 1'b1;
        @(negedge clock);
        abortar = 1'b0;
        drain(100);

        // Full address range: 0..15, no wrap
        for (int i = 0; i < 16; i++) mem[i] = DATA_W'(1 << (i % 4));
        push_normal(15);
        start_run(15);
        drain(400);
        check_eq("final_endereco", 32'(endereco), 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "timeout");
    end

endmodule
